// File: rtl/row_reorder_buf_pkg.sv
// Shared definitions for the row reorder buffer: default widths, item layout
// helpers and drain FSM state encoding.
package mac_rob_pkg;

  localparam int ROW_W_DEF = 11;
  localparam int COL_W_DEF = 8;

  // item = {size[1:0], los, col[COL_W-1:0]}
  function automatic int item_w(input int col_w);
    return col_w + 3;
  endfunction

  function automatic int los_bit(input int col_w);
    return col_w;
  endfunction

  function automatic int size_lsb(input int col_w);
    return col_w + 1;
  endfunction

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_MISS   = 2'd2;

endpackage

// File: rtl/row_reorder_buf_if.sv
// Write, drain-request and item-stream handshakes of the row reorder buffer.
interface row_reorder_buf_if import mac_rob_pkg::*; #(
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF
);
  localparam int ITEM_W = item_w(COL_W);

  logic              valid;
  logic              ready;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [1:0]        size;
  logic              los;

  logic              rd_valid;
  logic              rd_ready;
  logic [ROW_W-1:0]  rd_row;

  logic              item_valid;
  logic              item_ready;
  logic [ITEM_W-1:0] item;
  logic              item_end;
  logic              rd_miss;
  logic              full;
  logic              empty;

  modport master (
    output valid, row, col, size, los, rd_valid, rd_row, item_ready,
    input  ready, rd_ready, item_valid, item, item_end, rd_miss, full, empty
  );

  modport slave (
    input  valid, row, col, size, los, rd_valid, rd_row, item_ready,
    output ready, rd_ready, item_valid, item, item_end, rd_miss, full, empty
  );
endinterface

// File: rtl/row_reorder_buf_rob_slot.sv
// One row slot: tag, valid, fill count and a WAYS-deep item array kept in
// write order. Item storage is not reset.
module rob_slot import mac_rob_pkg::*; #(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int ITEM_W = item_w(COL_W_DEF),
  parameter int WAYS   = 8,
  parameter int IDX_W  = $clog2(WAYS),
  parameter int CNT_W  = IDX_W + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              alloc,
  input  logic              append,
  input  logic              clear,
  input  logic [ROW_W-1:0]  new_tag,
  input  logic [ITEM_W-1:0] wr_item,
  input  logic [IDX_W-1:0]  rd_way,
  output logic              valid,
  output logic [ROW_W-1:0]  tag,
  output logic [CNT_W-1:0]  count,
  output logic [ITEM_W-1:0] rd_item
);

  logic [ITEM_W-1:0] mem [WAYS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      tag   <= '0;
      count <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      count <= '0;
    end else if (alloc) begin
      valid <= 1'b1;
      tag   <= new_tag;
      count <= CNT_W'(1);
    end else if (append) begin
      count <= count + CNT_W'(1);
    end
  end

  // append is never issued on a full slot, so count indexes a free way
  always_ff @(posedge clk) begin
    if (alloc)
      mem[0] <= wr_item;
    else if (append)
      mem[count[IDX_W-1:0]] <= wr_item;
  end

  assign rd_item = mem[rd_way];

endmodule

// File: rtl/row_reorder_buf.sv
// Row reorder buffer: gathers column requests per DRAM row into slots and
// streams a whole row out on demand.
//   state     | meaning
//   ST_IDLE   | no drain active, drain request may be accepted
//   ST_STREAM | emitting items of slot dslot, ptr = next index to load
//   ST_MISS   | presenting the single miss/end beat
module row_reorder_buf import mac_rob_pkg::*; #(
  parameter int ROW_W    = ROW_W_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int NUM_SLOT = 4,
  parameter int WAYS     = 8
) (
  input logic              clk,
  input logic              resetn,
  row_reorder_buf_if.slave bus
);

  localparam int ITEM_W = item_w(COL_W);
  localparam int IDX_W  = $clog2(WAYS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int SLOT_W = $clog2(NUM_SLOT);

  logic [NUM_SLOT-1:0] slot_valid, wr_hit, rd_hit, alloc, append, clear;
  logic [ROW_W-1:0]    slot_tag  [NUM_SLOT];
  logic [CNT_W-1:0]    slot_cnt  [NUM_SLOT];
  logic [ITEM_W-1:0]   slot_item [NUM_SLOT];

  logic [1:0]        state;
  logic [SLOT_W-1:0] dslot, wr_idx, rd_idx, free_idx, sel;
  logic [CNT_W-1:0]  ptr, sel_cnt;
  logic [IDX_W-1:0]  rd_way;
  logic [ITEM_W-1:0] wr_item, sel_item, item_q;
  logic              wr_any, rd_any, accept, rd_accept, beat_done, block;
  logic              valid_q, end_q, miss_q;

  assign wr_item = {bus.size, bus.los, bus.col};

  always_comb begin
    wr_idx   = '0;
    rd_idx   = '0;
    free_idx = '0;
    for (int i = NUM_SLOT - 1; i >= 0; i--) begin
      if (!slot_valid[i]) free_idx = SLOT_W'(i);
      if (wr_hit[i])      wr_idx   = SLOT_W'(i);
      if (rd_hit[i])      rd_idx   = SLOT_W'(i);
    end
  end

  assign wr_any     = |wr_hit;
  assign rd_any     = |rd_hit;
  assign bus.full   = &slot_valid;
  assign bus.empty  = ~|slot_valid;

  // The drained row is frozen from acceptance until its last beat, so the
  // streamed count is exactly what was resident when the drain was taken.
  assign block = (state == ST_STREAM && slot_tag[dslot] == bus.row) ||
                 (state == ST_IDLE && bus.rd_valid && rd_any && bus.rd_row == bus.row);

  assign bus.ready    = !block && (wr_any ? (slot_cnt[wr_idx] != CNT_W'(WAYS)) : !bus.full);
  assign accept       = bus.valid && bus.ready;
  assign bus.rd_ready = (state == ST_IDLE);
  assign rd_accept    = bus.rd_valid && bus.rd_ready;
  assign beat_done    = valid_q && bus.item_ready;

  assign sel      = (state == ST_IDLE) ? rd_idx : dslot;
  assign rd_way   = (state == ST_IDLE) ? '0 : ptr[IDX_W-1:0];
  assign sel_item = slot_item[sel];
  assign sel_cnt  = slot_cnt[sel];

  for (genvar g = 0; g < NUM_SLOT; g++) begin : g_slot
    assign wr_hit[g] = slot_valid[g] && (slot_tag[g] == bus.row);
    assign rd_hit[g] = slot_valid[g] && (slot_tag[g] == bus.rd_row);
    assign alloc[g]  = accept && !wr_any && (free_idx == SLOT_W'(g));
    assign append[g] = accept && wr_any && (wr_idx == SLOT_W'(g));
    assign clear[g]  = (state == ST_STREAM) && beat_done && end_q && (dslot == SLOT_W'(g));

    rob_slot #(
      .ROW_W (ROW_W),
      .ITEM_W(ITEM_W),
      .WAYS  (WAYS)
    ) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .alloc  (alloc[g]),
      .append (append[g]),
      .clear  (clear[g]),
      .new_tag(bus.row),
      .wr_item(wr_item),
      .rd_way (rd_way),
      .valid  (slot_valid[g]),
      .tag    (slot_tag[g]),
      .count  (slot_cnt[g]),
      .rd_item(slot_item[g])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      dslot   <= '0;
      ptr     <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      miss_q  <= 1'b0;
      item_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_accept) begin
            valid_q <= 1'b1;
            if (rd_any) begin
              state  <= ST_STREAM;
              dslot  <= rd_idx;
              ptr    <= CNT_W'(1);
              item_q <= sel_item;
              end_q  <= (sel_cnt == CNT_W'(1));
            end else begin
              state  <= ST_MISS;
              item_q <= '0;
              end_q  <= 1'b1;
              miss_q <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (beat_done) begin
            if (end_q) begin
              state   <= ST_IDLE;
              valid_q <= 1'b0;
              end_q   <= 1'b0;
            end else begin
              item_q <= sel_item;
              end_q  <= (ptr == sel_cnt - CNT_W'(1));
              ptr    <= ptr + CNT_W'(1);
            end
          end
        end
        ST_MISS: begin
          if (beat_done) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            miss_q  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.item_valid = valid_q;
  assign bus.item_end   = end_q;
  assign bus.rd_miss    = miss_q;
  assign bus.item       = item_q;

endmodule

// File: tb/tb_row_reorder_buf.sv
// Self-checking bench for row_reorder_buf against a per-row queue model.
module tb_row_reorder_buf;

  localparam int ROW_W    = 11;
  localparam int COL_W    = 8;
  localparam int NUM_SLOT = 4;
  localparam int WAYS     = 8;
  localparam int ITEM_W   = COL_W + 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  row_reorder_buf_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus();

  row_reorder_buf #(
    .ROW_W(ROW_W), .COL_W(COL_W), .NUM_SLOT(NUM_SLOT), .WAYS(WAYS)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: resident rows and their items in arrival order
  logic [ITEM_W-1:0] mq [128][$];
  bit                mres [128];
  int                nres;

  logic [ITEM_W-1:0] g_item [$];
  bit                g_end [$];
  bit                g_miss [$];
  int                g_cyc [$];
  int                acc_cyc;
  bit                drain_to;

  function automatic void model_clear();
    for (int i = 0; i < 128; i++) begin
      mq[i].delete();
      mres[i] = 1'b0;
    end
    nres = 0;
  endfunction

  function automatic bit model_can_write(input int row);
    if (mres[row]) return mq[row].size() < WAYS;
    return nres < NUM_SLOT;
  endfunction

  function automatic void model_write(input int row, input logic [ITEM_W-1:0] it);
    if (!mres[row]) begin
      mres[row] = 1'b1;
      nres++;
    end
    mq[row].push_back(it);
  endfunction

  function automatic void model_drained(input int row);
    if (mres[row]) begin
      mres[row] = 1'b0;
      nres--;
    end
    mq[row].delete();
  endfunction

  function automatic logic [ITEM_W-1:0] rnd_item();
    logic [ITEM_W-1:0] it;
    it = ITEM_W'($urandom);
    return it;
  endfunction

  task automatic idle_inputs();
    bus.valid = 1'b0; bus.row = '0; bus.col = '0; bus.size = '0; bus.los = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_row = '0; bus.item_ready = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  // leaves time at posedge+1; model follows what the DUT actually took
  task automatic do_write(input int row, input logic [ITEM_W-1:0] it, output bit acc);
    bus.valid = 1'b1;
    bus.row   = ROW_W'(row);
    {bus.size, bus.los, bus.col} = it;
    @(negedge clk);
    acc = bus.ready;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    if (acc) model_write(row, it);
  endtask

  task automatic drain(input int row, input bit rnd);
    bit done;
    g_item.delete(); g_end.delete(); g_miss.delete(); g_cyc.delete();
    bus.rd_valid = 1'b1;
    bus.rd_row   = ROW_W'(row);
    @(negedge clk);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.rd_valid = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      bus.item_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.item_valid && bus.item_ready) begin
        g_item.push_back(bus.item);
        g_end.push_back(bus.item_end);
        g_miss.push_back(bus.rd_miss);
        g_cyc.push_back(cyc);
        if (bus.item_end) done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.item_ready = 1'b0;
    drain_to = !done;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.item_valid !== 1'b0) begin bad++; $display("FAIL reset_item_valid got=%0b exp=0", bus.item_valid); end
    total++; if (bus.item_end !== 1'b0) begin bad++; $display("FAIL reset_item_end got=%0b exp=0", bus.item_end); end
    total++; if (bus.rd_miss !== 1'b0) begin bad++; $display("FAIL reset_rd_miss got=%0b exp=0", bus.rd_miss); end
    total++; if (bus.item !== '0) begin bad++; $display("FAIL reset_item got=%0h exp=0", bus.item); end
    total++; if ({bus.full, bus.empty} !== 2'b01) begin bad++; $display("FAIL reset_full_empty got=%0b%0b exp=01", bus.full, bus.empty); end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    @(negedge clk);
    total++; if (bus.rd_ready !== 1'b1) begin bad++; $display("FAIL reset_rd_ready got=%0b exp=1", bus.rd_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [ITEM_W-1:0] exp_q [$];
    bit acc, exp;
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      exp = model_can_write(5);
      do_write(5, {2'($urandom), 1'($urandom), COL_W'(c)}, acc);
      total++; if (acc !== exp) begin bad++; $display("FAIL basic_write%0d got=%0b exp=%0b", c, acc, exp); end
    end
    exp_q = mq[5];
    drain(5, 1'b0);
    model_drained(5);
    total++; if (drain_to || g_item.size() != exp_q.size()) begin bad++; $display("FAIL basic_beats got=%0d exp=%0d", g_item.size(), exp_q.size()); end
    for (int k = 0; k < g_item.size() && k < exp_q.size(); k++) begin
      total++; if (g_item[k] !== exp_q[k]) begin bad++; $display("FAIL basic_item%0d got=%0h exp=%0h", k, g_item[k], exp_q[k]); end
      total++; if (g_end[k] !== (k == 2)) begin bad++; $display("FAIL basic_end%0d got=%0b exp=%0b", k, g_end[k], k == 2); end
      total++; if (g_cyc[k] != acc_cyc + 1 + k) begin bad++; $display("FAIL basic_cycle%0d got=%0d exp=%0d", k, g_cyc[k], acc_cyc + 1 + k); end
    end
    @(negedge clk);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%0b exp=1", bus.empty); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full();
    logic [ITEM_W-1:0] exp_q [$];
    bit acc, exp;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      exp = model_can_write(r);
      do_write(r, rnd_item(), acc);
      total++; if (acc !== exp) begin bad++; $display("FAIL full_fill%0d got=%0b exp=%0b", r, acc, exp); end
    end
    @(negedge clk);
    total++; if (bus.full !== (nres == NUM_SLOT)) begin bad++; $display("FAIL full_flag got=%0b exp=%0b", bus.full, nres == NUM_SLOT); end
    @(posedge clk);
    #1;
    exp = model_can_write(9);
    do_write(9, rnd_item(), acc);
    total++; if (acc !== exp) begin bad++; $display("FAIL full_refuse9 got=%0b exp=%0b", acc, exp); end
    exp_q = mq[0];
    drain(0, 1'b0);
    model_drained(0);
    total++; if (drain_to || g_item.size() != 1 || g_item[0] !== exp_q[0] || g_miss[0] !== 1'b0) begin
      bad++; $display("FAIL full_drain0 got_beats=%0d exp_beats=1", g_item.size()); end
    exp = model_can_write(9);
    do_write(9, rnd_item(), acc);
    total++; if (acc !== exp) begin bad++; $display("FAIL full_accept9 got=%0b exp=%0b", acc, exp); end
  endtask

  task automatic test_ways();
    logic [ITEM_W-1:0] exp_q [$];
    bit acc, exp;
    apply_reset();
    for (int k = 0; k <= WAYS; k++) begin
      exp = model_can_write(3);
      do_write(3, rnd_item(), acc);
      total++; if (acc !== exp) begin bad++; $display("FAIL ways_row3_w%0d got=%0b exp=%0b", k, acc, exp); end
    end
    exp = model_can_write(4);
    do_write(4, rnd_item(), acc);
    total++; if (acc !== exp) begin bad++; $display("FAIL ways_row4 got=%0b exp=%0b", acc, exp); end
    exp_q = mq[3];
    drain(3, 1'b1);
    model_drained(3);
    total++; if (drain_to || g_item.size() != exp_q.size()) begin bad++; $display("FAIL ways_beats got=%0d exp=%0d", g_item.size(), exp_q.size()); end
    for (int k = 0; k < g_item.size() && k < exp_q.size(); k++) begin
      total++; if (g_item[k] !== exp_q[k] || g_end[k] !== (k == exp_q.size() - 1)) begin
        bad++; $display("FAIL ways_item%0d got=%0h/%0b exp=%0h/%0b", k, g_item[k], g_end[k], exp_q[k], k == exp_q.size() - 1); end
    end
  endtask

  task automatic test_miss();
    bit acc;
    apply_reset();
    do_write(5, rnd_item(), acc);
    drain(77, 1'b1);
    total++; if (drain_to || g_item.size() != 1) begin bad++; $display("FAIL miss_beats got=%0d exp=1", g_item.size()); end
    if (g_item.size() > 0) begin
      total++; if ({g_miss[0], g_end[0]} !== 2'b11) begin bad++; $display("FAIL miss_flags got=%0b%0b exp=11", g_miss[0], g_end[0]); end
      total++; if (g_item[0] !== '0) begin bad++; $display("FAIL miss_item got=%0h exp=0", g_item[0]); end
    end
  endtask

  task automatic test_stall();
    logic [ITEM_W-1:0] exp_q [$];
    logic [ITEM_W-1:0] prev_item;
    bit pat [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    bit acc, exp, prev_stall, done;
    apply_reset();
    for (int c = 0; c < 3; c++) do_write(5, rnd_item(), acc);
    exp_q = mq[5];
    g_item.delete();
    bus.rd_valid = 1'b1; bus.rd_row = ROW_W'(5);
    @(negedge clk); @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    prev_stall = 1'b0; prev_item = '0; done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      bus.item_ready = (k < 8) ? pat[k] : 1'b1;
      bus.valid = 1'b1; bus.row = ROW_W'(5); bus.col = COL_W'($urandom);
      @(negedge clk);
      total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL stall_refuse_row5 k=%0d got=%0b exp=0", k, bus.ready); end
      if (prev_stall) begin
        total++; if (bus.item_valid !== 1'b1 || bus.item !== prev_item) begin
          bad++; $display("FAIL stall_hold k=%0d got=%0h exp=%0h", k, bus.item, prev_item); end
      end
      prev_stall = bus.item_valid && !bus.item_ready;
      prev_item  = bus.item;
      if (bus.item_valid && bus.item_ready) begin
        g_item.push_back(bus.item);
        if (bus.item_end) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.valid = 1'b0; bus.item_ready = 1'b0;
    model_drained(5);
    total++; if (!done || g_item.size() != 3) begin bad++; $display("FAIL stall_beats got=%0d exp=3", g_item.size()); end
    for (int k = 0; k < g_item.size() && k < 3; k++) begin
      total++; if (g_item[k] !== exp_q[k]) begin bad++; $display("FAIL stall_item%0d got=%0h exp=%0h", k, g_item[k], exp_q[k]); end
    end
    exp = model_can_write(5);
    do_write(5, rnd_item(), acc);
    total++; if (acc !== exp) begin bad++; $display("FAIL stall_after_idle got=%0b exp=%0b", acc, exp); end
  endtask

  task automatic test_concurrent();
    logic [ITEM_W-1:0] exp_q [$];
    logic [ITEM_W-1:0] it;
    bit acc, exp, done;
    apply_reset();
    do_write(1, rnd_item(), acc);
    do_write(1, rnd_item(), acc);
    do_write(2, rnd_item(), acc);
    exp_q = mq[1];
    g_item.delete();
    bus.rd_valid = 1'b1; bus.rd_row = ROW_W'(1);
    @(negedge clk); @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      it = rnd_item();
      bus.item_ready = 1'b1;
      bus.valid = 1'b1; bus.row = ROW_W'(2); {bus.size, bus.los, bus.col} = it;
      @(negedge clk);
      exp = model_can_write(2);
      acc = bus.ready;
      total++; if (acc !== exp) begin bad++; $display("FAIL conc_write k=%0d got=%0b exp=%0b", k, acc, exp); end
      if (bus.item_valid) begin
        g_item.push_back(bus.item);
        if (bus.item_end) done = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) model_write(2, it);
    end
    bus.valid = 1'b0; bus.item_ready = 1'b0;
    model_drained(1);
    total++; if (g_item.size() != 2 || g_item[0] !== exp_q[0] || g_item[1] !== exp_q[1]) begin
      bad++; $display("FAIL conc_drain1 got_beats=%0d exp_beats=2", g_item.size()); end
    exp_q = mq[2];
    drain(2, 1'b0);
    model_drained(2);
    total++; if (drain_to || g_item != exp_q) begin bad++; $display("FAIL conc_drain2 got_beats=%0d exp_beats=%0d", g_item.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    logic [ITEM_W-1:0] exp_q [$];
    bit acc, exp, hit;
    int row;
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      total++; if (bus.full !== (nres == NUM_SLOT) || bus.empty !== (nres == 0)) begin
        bad++; $display("FAIL rnd_flags n=%0d got=%0b%0b exp=%0b%0b", n, bus.full, bus.empty, nres == NUM_SLOT, nres == 0); end
      @(posedge clk); #1;
      if ($urandom_range(0, 3) != 0) begin
        row = $urandom_range(0, 5);
        exp = model_can_write(row);
        do_write(row, rnd_item(), acc);
        total++; if (acc !== exp) begin bad++; $display("FAIL rnd_write n=%0d row=%0d got=%0b exp=%0b", n, row, acc, exp); end
      end else begin
        row = $urandom_range(0, 6);
        hit = mres[row];
        exp_q = mq[row];
        drain(row, 1'b1);
        model_drained(row);
        if (hit) begin
          total++; if (drain_to || g_item != exp_q || g_miss[0] !== 1'b0) begin
            bad++; $display("FAIL rnd_drain n=%0d row=%0d got_beats=%0d exp_beats=%0d", n, row, g_item.size(), exp_q.size()); end
        end else begin
          total++; if (drain_to || g_item.size() != 1 || g_miss[0] !== 1'b1 || g_item[0] !== '0) begin
            bad++; $display("FAIL rnd_miss n=%0d row=%0d got_beats=%0d exp_beats=1", n, row, g_item.size()); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    apply_reset();
    for (int c = 0; c < 3; c++) do_write(5, rnd_item(), acc);
    bus.rd_valid = 1'b1; bus.rd_row = ROW_W'(5);
    @(negedge clk); @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    bus.item_ready = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    total++; if ({bus.item_valid, bus.item_end, bus.rd_miss} !== 3'b000) begin
      bad++; $display("FAIL midrst_flags got=%0b%0b%0b exp=000", bus.item_valid, bus.item_end, bus.rd_miss); end
    total++; if (bus.item !== '0) begin bad++; $display("FAIL midrst_item got=%0h exp=0", bus.item); end
    total++; if ({bus.full, bus.empty} !== 2'b01) begin bad++; $display("FAIL midrst_full_empty got=%0b%0b exp=01", bus.full, bus.empty); end
    bus.item_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      bus.item_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.item_valid !== 1'b0 || bus.rd_ready !== 1'b1) begin
        bad++; $display("FAIL midrst_after k=%0d got_valid=%0b got_rd_ready=%0b exp=0/1", k, bus.item_valid, bus.rd_ready); end
      @(posedge clk); #1;
    end
    bus.item_ready = 1'b0;
    drain(5, 1'b0);
    total++; if (drain_to || g_item.size() != 1 || g_miss[0] !== 1'b1) begin
      bad++; $display("FAIL midrst_slot_freed got_beats=%0d exp=1 miss", g_item.size()); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_full();
    test_ways();
    test_miss();
    test_stall();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
